// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one of ALU / load-store / branch results per cycle
// and registers it onto the CDB; mispredicted branches bypass the round-robin order.
module cdb_arbiter #(
    parameter int rob_index_bits = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_req,
    input  logic [rob_index_bits-1:0] alu_tag,
    input  logic [31:0]               alu_data,
    input  logic                      ls_req,
    input  logic [rob_index_bits-1:0] ls_tag,
    input  logic [31:0]               ls_data,
    input  logic                      br_req,
    input  logic [rob_index_bits-1:0] br_tag,
    input  logic [31:0]               br_data,
    input  logic                      br_mispredict,
    input  logic                      rob_wb_ready,
    input  logic                      flush,
    output logic                      alu_gnt,
    output logic                      ls_gnt,
    output logic                      br_gnt,
    output logic                      cdb_valid,
    output logic [rob_index_bits-1:0] cdb_tag,
    output logic [31:0]               cdb_data,
    output logic [1:0]                cdb_src,
    output logic                      cdb_mispredict
);

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_LS  = 2'd1;
    localparam logic [1:0] SRC_BR  = 2'd2;

    logic [1:0]                ptr_q, ptr_d;
    logic                      cdb_valid_q, cdb_valid_d;
    logic [rob_index_bits-1:0] cdb_tag_q, cdb_tag_d;
    logic [31:0]               cdb_data_q, cdb_data_d;
    logic [1:0]                cdb_src_q, cdb_src_d;
    logic                      cdb_mispredict_q, cdb_mispredict_d;

    logic [2:0]                req_vec;
    logic [2:0]                gnt_vec;
    logic                      arb_en;
    logic                      mp_win;
    logic                      grant;
    logic                      found;
    logic [1:0]                ptr_eff;
    logic [1:0]                win_src;
    logic [2:0]                cand_sum;
    logic [1:0]                cand;
    logic [rob_index_bits-1:0] win_tag;
    logic [31:0]               win_data;

    // Grant selection
    always_comb begin
        req_vec  = {br_req, ls_req, alu_req};
        arb_en   = !rst && !flush && rob_wb_ready;
        mp_win   = arb_en && br_req && br_mispredict;
        ptr_eff  = (ptr_q == 2'd3) ? SRC_ALU : ptr_q;
        gnt_vec  = 3'b000;
        win_src  = SRC_ALU;
        found    = 1'b0;
        cand_sum = 3'd0;
        cand     = 2'd0;
        if (mp_win) begin
            gnt_vec = 3'b100;
            win_src = SRC_BR;
        end else if (arb_en) begin
            for (int k = 0; k < 3; k++) begin
                cand_sum = {1'b0, ptr_eff} + 3'(k);
                cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3)
                                              : cand_sum[1:0];
                if (!found && req_vec[cand]) begin
                    found         = 1'b1;
                    gnt_vec[cand] = 1'b1;
                    win_src       = cand;
                end
            end
        end
        grant = |gnt_vec;
    end

    always_comb begin
        alu_gnt = gnt_vec[0];
        ls_gnt  = gnt_vec[1];
        br_gnt  = gnt_vec[2];
    end

    always_comb begin
        win_tag  = alu_tag;
        win_data = alu_data;
        case (win_src)
            SRC_LS: begin
                win_tag  = ls_tag;
                win_data = ls_data;
            end
            SRC_BR: begin
                win_tag  = br_tag;
                win_data = br_data;
            end
            default: begin
                win_tag  = alu_tag;
                win_data = alu_data;
            end
        endcase
    end

    // Mispredict overrides leave the round-robin pointer untouched
    always_comb begin
        ptr_d = ptr_q;
        if (rst || flush) begin
            ptr_d = SRC_ALU;
        end else if (grant && !mp_win) begin
            ptr_d = (win_src == SRC_BR) ? SRC_ALU : 2'(win_src + 2'd1);
        end
    end

    always_comb begin
        cdb_valid_d      = 1'b0;
        cdb_tag_d        = cdb_tag_q;
        cdb_data_d       = cdb_data_q;
        cdb_src_d        = cdb_src_q;
        cdb_mispredict_d = cdb_mispredict_q;
        if (flush) begin
            cdb_mispredict_d = 1'b0;
        end else if (grant) begin
            cdb_valid_d      = 1'b1;
            cdb_tag_d        = win_tag;
            cdb_data_d       = win_data;
            cdb_src_d        = win_src;
            cdb_mispredict_d = mp_win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q            <= SRC_ALU;
            cdb_valid_q      <= 1'b0;
            cdb_tag_q        <= '0;
            cdb_data_q       <= 32'd0;
            cdb_src_q        <= SRC_ALU;
            cdb_mispredict_q <= 1'b0;
        end else begin
            ptr_q            <= ptr_d;
            cdb_valid_q      <= cdb_valid_d;
            cdb_tag_q        <= cdb_tag_d;
            cdb_data_q       <= cdb_data_d;
            cdb_src_q        <= cdb_src_d;
            cdb_mispredict_q <= cdb_mispredict_d;
        end
    end

    assign cdb_valid      = cdb_valid_q;
    assign cdb_tag        = cdb_tag_q;
    assign cdb_data       = cdb_data_q;
    assign cdb_src        = cdb_src_q;
    assign cdb_mispredict = cdb_mispredict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic, every cycle
// compared against a queue-free behavioural model of the bus.
module tb_cdb_arbiter;

    localparam int RB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_req, ls_req, br_req, br_mispredict;
    logic [RB-1:0] alu_tag, ls_tag, br_tag;
    logic [31:0]   alu_data, ls_data, br_data;
    logic          rob_wb_ready, flush;
    logic          alu_gnt, ls_gnt, br_gnt;
    logic          cdb_valid, cdb_mispredict;
    logic [RB-1:0] cdb_tag;
    logic [31:0]   cdb_data;
    logic [1:0]    cdb_src;

    int passed = 0;
    int total  = 0;

    // model state
    int          m_ptr = 0;
    logic        m_valid = 0, m_mp = 0;
    logic [31:0] m_tag = 0, m_data = 0, m_src = 0;
    int          last_g = -1;

    always #5 clk = ~clk;

    cdb_arbiter #(.rob_index_bits(RB)) dut (
        .clk(clk), .rst(rst),
        .alu_req(alu_req), .alu_tag(alu_tag), .alu_data(alu_data),
        .ls_req(ls_req), .ls_tag(ls_tag), .ls_data(ls_data),
        .br_req(br_req), .br_tag(br_tag), .br_data(br_data),
        .br_mispredict(br_mispredict), .rob_wb_ready(rob_wb_ready),
        .flush(flush),
        .alu_gnt(alu_gnt), .ls_gnt(ls_gnt), .br_gnt(br_gnt),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_src(cdb_src), .cdb_mispredict(cdb_mispredict)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Which source should win this cycle (-1 none); sets mp if override
    function automatic int model_pick(output bit mp);
        bit r[3];
        mp = 0;
        r[0] = alu_req; r[1] = ls_req; r[2] = br_req;
        if (rst || flush || !rob_wb_ready) return -1;
        if (br_req && br_mispredict) begin
            mp = 1;
            return 2;
        end
        for (int k = 0; k < 3; k++)
            if (r[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        return -1;
    endfunction

    task automatic step(input string nm);
        int g;
        bit mp;
        #1;
        g = model_pick(mp);
        last_g = g;
        chk({nm, ".alu_gnt"}, 32'(alu_gnt), 32'(g == 0));
        chk({nm, ".ls_gnt"},  32'(ls_gnt),  32'(g == 1));
        chk({nm, ".br_gnt"},  32'(br_gnt),  32'(g == 2));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_tag = 0; m_data = 0; m_src = 0; m_mp = 0;
            m_ptr = 0;
        end else if (flush) begin
            m_valid = 0; m_mp = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1;
            m_src   = 32'(g);
            m_mp    = mp;
            m_tag   = (g == 0) ? 32'(alu_tag) : (g == 1) ? 32'(ls_tag)
                                              : 32'(br_tag);
            m_data  = (g == 0) ? alu_data : (g == 1) ? ls_data : br_data;
            if (!mp) m_ptr = (g + 1) % 3;
        end else begin
            m_valid = 0;
        end
        #1;
        chk({nm, ".cdb_valid"}, 32'(cdb_valid), 32'(m_valid));
        chk({nm, ".cdb_tag"},   32'(cdb_tag),   m_tag);
        chk({nm, ".cdb_data"},  cdb_data,       m_data);
        chk({nm, ".cdb_src"},   32'(cdb_src),   m_src);
        chk({nm, ".cdb_mp"},    32'(cdb_mispredict), 32'(m_mp));
    endtask

    task automatic idle_inputs();
        alu_req = 0; ls_req = 0; br_req = 0; br_mispredict = 0;
        flush = 0; rob_wb_ready = 1;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        alu_tag = 4'd1; alu_data = 32'h1111_0000;
        ls_tag  = 4'd2; ls_data  = 32'h2222_0000;
        br_tag  = 4'd3; br_data  = 32'h3333_0000;
        step("rst0");
        step("rst1");
        chk("reset.valid", 32'(cdb_valid), 32'd0);

        // all requesting: ALU, LS, BR, ALU
        rst = 0;
        alu_req = 1; ls_req = 1; br_req = 1;
        step("rr0"); chk("rr0.src_seq", 32'(cdb_src), 32'd0);
        step("rr1"); chk("rr1.src_seq", 32'(cdb_src), 32'd1);
        step("rr2"); chk("rr2.src_seq", 32'(cdb_src), 32'd2);
        step("rr3"); chk("rr3.src_seq", 32'(cdb_src), 32'd0);

        // lone LS request
        idle_inputs();
        ls_req = 1; ls_tag = 4'd5; ls_data = 32'hDEADBEEF;
        step("ls");
        chk("ls.data", cdb_data, 32'hDEADBEEF);
        chk("ls.tag", 32'(cdb_tag), 32'd5);

        // BR grant moves ptr to 0, then mispredict override vs ALU
        idle_inputs();
        br_req = 1;
        step("br_plain");
        alu_req = 1; br_req = 1; br_mispredict = 1; br_tag = 4'd9;
        step("mp");
        chk("mp.flag", 32'(cdb_mispredict), 32'd1);
        chk("mp.tag", 32'(cdb_tag), 32'd9);
        br_req = 0; br_mispredict = 0;
        step("mp_after");
        chk("mp_after.src", 32'(cdb_src), 32'd0);

        // ROB stall for three cycles
        alu_req = 1; ls_req = 1; br_req = 1;
        rob_wb_ready = 0;
        step("stall0"); step("stall1"); step("stall2");
        rob_wb_ready = 1;
        step("resume");
        chk("resume.src", 32'(cdb_src), 32'd1);

        // ALU grant then flush
        idle_inputs();
        rst = 1; step("rst_pre_flush");
        rst = 0; alu_req = 1; ls_req = 1; br_req = 1;
        step("pre_flush");
        flush = 1;
        step("flush");
        chk("flush.valid", 32'(cdb_valid), 32'd0);
        flush = 0;
        step("post_flush");
        chk("post_flush.src", 32'(cdb_src), 32'd0);

        // reset mid-stream
        rst = 1;
        step("mid_rst0"); step("mid_rst1");
        rst = 0;
        step("mid_rst_rel");
        chk("mid_rst_rel.src", 32'(cdb_src), 32'd0);

        // random traffic honouring hold-until-granted
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            bit drop;
            drop = rst || flush;
            rst   = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 4);
            rob_wb_ready = ($urandom_range(0, 99) < 80);
            if (drop || last_g == 0 || !alu_req) begin
                alu_req  = $urandom_range(0, 1);
                alu_tag  = RB'($urandom);
                alu_data = $urandom;
            end
            if (drop || last_g == 1 || !ls_req) begin
                ls_req  = $urandom_range(0, 1);
                ls_tag  = RB'($urandom);
                ls_data = $urandom;
            end
            if (drop || last_g == 2 || !br_req) begin
                br_req        = $urandom_range(0, 1);
                br_mispredict = ($urandom_range(0, 3) == 0);
                br_tag        = RB'($urandom);
                br_data       = $urandom;
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
